// File: rtl/simon_pkg.sv
// Shared constants, types and helpers for the Simon 64/128 key schedule.
// Z3 is stored MSB-first so that sequence bit j lives at Z3[61-j].
package simon_pkg;

    localparam int WORD_W     = 32;
    localparam int NUM_ROUNDS = 44;

    localparam logic [61:0] Z3 =
        62'b11011011101011000110010111100000010010001010011100110100001111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ks_state_e;

    function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x,
                                              input int unsigned        n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

endpackage

// File: rtl/simon_ks_step.sv
// One step of the Simon 64/128 (m = 4) key expansion: next key word from
// the oldest word w0, w1, the newest word w3 and the current z3 bit.
module simon_ks_step
    import simon_pkg::*;
(
    input  logic [WORD_W-1:0] w0,
    input  logic [WORD_W-1:0] w1,
    input  logic [WORD_W-1:0] w3,
    input  logic              zbit,
    output logic [WORD_W-1:0] w_new
);

    logic [WORD_W-1:0] t0;
    logic [WORD_W-1:0] t1;

    assign t0 = ror(w3, 3) ^ w1;
    assign t1 = t0 ^ ror(t0, 1);

    // ~w0 ^ 3 is the usual constant c = 2^n - 4 folded into the old word
    assign w_new = ~w0 ^ t1 ^ WORD_W'(3) ^ {{(WORD_W-1){1'b0}}, zbit};

endmodule

// File: rtl/simon_key_schedule.sv
// Simon 64/128 round-key generator: accepts a 128-bit master key and streams
// the 44 round keys, one word per rk handshake, from a 4-word shift window.
module simon_key_schedule #(
    parameter int WORD_W     = simon_pkg::WORD_W,
    parameter int NUM_ROUNDS = simon_pkg::NUM_ROUNDS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [4*WORD_W-1:0] key,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [WORD_W-1:0]   rk,
    output logic [5:0]          rk_idx,
    output logic                rk_last
);

    // state   | meaning
    // ST_IDLE | waiting for a master key, key_ready high
    // ST_RUN  | presenting round key idx in w0, rk_valid high
    import simon_pkg::ks_state_e;
    import simon_pkg::ST_IDLE;
    import simon_pkg::ST_RUN;
    import simon_pkg::Z3;

    localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

    ks_state_e         state_q;
    ks_state_e         state_d;
    logic [WORD_W-1:0] w0;
    logic [WORD_W-1:0] w1;
    logic [WORD_W-1:0] w2;
    logic [WORD_W-1:0] w3;
    logic [WORD_W-1:0] w_new;
    logic [5:0]        idx;
    logic              load;
    logic              hs;
    logic              at_last;
    logic              zbit;

    assign load    = (state_q == ST_IDLE) && key_valid;
    assign hs      = (state_q == ST_RUN) && rk_ready;
    assign at_last = (idx == LAST_IDX);
    assign zbit    = Z3[6'd61 - idx];

    simon_ks_step u_step (
        .w0    (w0),
        .w1    (w1),
        .w3    (w3),
        .zbit  (zbit),
        .w_new (w_new)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (key_valid)            state_d = ST_RUN;
            ST_RUN:  if (rk_ready && at_last)  state_d = ST_IDLE;
            default:                           state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            w0      <= '0;
            w1      <= '0;
            w2      <= '0;
            w3      <= '0;
            idx     <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                w0  <= key[WORD_W-1:0];
                w1  <= key[2*WORD_W-1:WORD_W];
                w2  <= key[3*WORD_W-1:2*WORD_W];
                w3  <= key[4*WORD_W-1:3*WORD_W];
                idx <= '0;
            end else if (hs) begin
                w0  <= w1;
                w1  <= w2;
                w2  <= w3;
                w3  <= w_new;
                // idx wraps to 0 when the stream ends so IDLE always shows 0
                idx <= at_last ? 6'd0 : idx + 6'd1;
            end
        end
    end

    assign key_ready = (state_q == ST_IDLE);
    assign rk_valid  = (state_q == ST_RUN);
    assign rk        = w0;
    assign rk_idx    = idx;
    assign rk_last   = (state_q == ST_RUN) && at_last;

endmodule

// File: tb/tb_simon_key_schedule.sv
// Directed bench for simon_key_schedule: stimulus pushes expected round keys
// into a scoreboard; a negedge monitor pops and compares on every rk handshake.
module tb_simon_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] key = '0;
    logic         rk_valid;
    logic         rk_ready = 1'b0;
    logic [31:0]  rk;
    logic [5:0]   rk_idx;
    logic         rk_last;

    localparam logic [127:0] KEY1 = 128'h1b1a1918_13121110_0b0a0908_03020100;
    localparam logic [127:0] KEY2 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    localparam logic [63:0]  PT   = 64'h656b696c_20646e75;
    localparam logic [63:0]  CT   = 64'h44c8fc20_b9dfa07a;

    typedef struct packed {
        logic [31:0] rk;
        logic [5:0]  idx;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          errors = 0;
    int          checks = 0;
    logic [63:0] ct_state = '0;
    logic [0:61] z3_tb = 62'b11011011101011000110010111100000010010001010011100110100001111;
    logic [31:0] exp_k [0:43];
    logic [31:0] hand_k [0:4] = '{32'h03020100, 32'h0b0a0908, 32'h13121110,
                                  32'h1b1a1918, 32'h70a011c3};

    simon_key_schedule dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key       (key),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk        (rk),
        .rk_idx    (rk_idx),
        .rk_last   (rk_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Reference key expansion written directly from the Simon recurrence
    task automatic build_keys(input logic [127:0] k);
        logic [31:0] tmp;
        for (int i = 0; i < 4; i++) exp_k[i] = k[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = {exp_k[i-1][2:0], exp_k[i-1][31:3]} ^ exp_k[i-3];
            tmp = tmp ^ {tmp[0], tmp[31:1]};
            exp_k[i] = 32'hffff_fffc ^ {31'd0, z3_tb[i-4]} ^ exp_k[i-4] ^ tmp;
        end
    endtask

    task automatic push_stream();
        exp_t x;
        for (int i = 0; i < 44; i++) begin
            x.rk   = (i < 5) ? hand_k[i] : exp_k[i];
            x.idx  = 6'(i);
            x.last = (i == 43);
            sb.push_back(x);
        end
    endtask

    function automatic logic [63:0] simon_round(input logic [63:0] s, input logic [31:0] k);
        logic [31:0] x;
        logic [31:0] f;
        x = s[63:32];
        f = ({x[30:0], x[31]} & {x[23:0], x[31:24]}) ^ {x[29:0], x[31:30]};
        return {s[31:0] ^ f ^ k, x};
    endfunction

    // Called just after a posedge; returns just after the accepting edge
    task automatic load(input logic [127:0] k);
        check("key_ready_before_load", {127'd0, key_ready}, 128'd1);
        key       = k;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        check("load_latency", {key_ready, rk_valid, rk_idx}, {1'b0, 1'b1, 6'd0});
    endtask

    task automatic wait_idx(input int target);
        for (int n = 0; n < 200; n++) begin
            if (rk_valid && rk_idx == 6'(target)) return;
            @(posedge clk); #1;
        end
        timeout($sformatf("wait_idx_%0d", target));
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200; n++) begin
            if (!rk_valid) return;
            @(posedge clk); #1;
        end
        timeout("wait_idle");
    endtask

    always @(negedge clk) begin
        if (rst_n && rk_valid && rk_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rk: got idx %0d rk %h, none expected", rk_idx, rk);
            end else begin
                e = sb.pop_front();
                check($sformatf("rk_stream_idx%0d", e.idx),
                      {89'd0, rk_idx, rk_last, rk}, {89'd0, e.idx, e.last, e.rk});
            end
            ct_state = simon_round((rk_idx == 6'd0) ? PT : ct_state, rk);
            if (rk_idx == 6'd43) check("ciphertext", {64'd0, ct_state}, {64'd0, CT});
        end
    end

    initial begin
        int n;
        build_keys(KEY1);

        #2;
        check("reset_outputs", {key_ready, rk_valid, rk_last, rk_idx, rk},
              {1'b1, 1'b0, 1'b0, 6'd0, 32'd0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full stream at full rate
        rk_ready = 1'b1;
        push_stream();
        load(KEY1);
        n = 1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (!rk_valid) break;
            n++;
        end
        check("throughput_cycles", 128'(n), 128'd44);
        check("key_ready_after_stream", {127'd0, key_ready}, 128'd1);

        // Stall at idx 10, then a foreign key offered at idx 20
        push_stream();
        load(KEY1);
        wait_idx(10);
        rk_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("stall_hold_%0d", c), {rk_valid, rk_last, rk_idx, rk},
                  {1'b1, 1'b0, 6'd10, exp_k[10]});
        end
        rk_ready = 1'b1;
        wait_idx(20);
        key       = KEY2;
        key_valid = 1'b1;
        @(posedge clk); #1;
        check("key_ignored_in_run", {key_ready, rk_valid, rk_idx}, {1'b0, 1'b1, 6'd21});
        key_valid = 1'b0;
        key       = KEY1;
        wait_idle();

        // Async reset mid-stream
        push_stream();
        load(KEY1);
        wait_idx(30);
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid_run", {key_ready, rk_valid, rk_last, rk_idx, rk},
              {1'b1, 1'b0, 1'b0, 6'd0, 32'd0});
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reload, then hold a second key for back-to-back acceptance
        push_stream();
        load(KEY1);
        push_stream();
        key_valid = 1'b1;
        n = 0;
        while (!(rk_valid && rk_last) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) timeout("wait_rk_last");
        @(posedge clk); #1;
        check("b2b_bubble", {key_ready, rk_valid}, {1'b1, 1'b0});
        @(posedge clk); #1;
        check("b2b_accept", {key_ready, rk_valid, rk_idx}, {1'b0, 1'b1, 6'd0});
        key_valid = 1'b0;
        wait_idle();
        @(posedge clk); #1;
        check("scoreboard_drained", 128'(sb.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
